// File: rtl/uc_multiciclo_param_if.sv
// uc_multiciclo_param_if
//   Bundles the control unit's datapath-facing signals.
//   master : the control unit drives the load/select strobes and State, and
//            samples the comparator flags and the instruction register.
//   slave  : the datapath side (mirror of master).
//   Signals: ET, LT, Instr31_0 (datapath -> control);
//            LoadIR, PCWrite, LoadOldPC, LoadRegA, LoadRegB, LoadMDR,
//            LoadAluout, WriteRegBanco, DMemWR, AluSrcA, AluSrcB, AluFct,
//            MemToReg, InstrType, State, Illegal (control -> datapath).
interface uc_multiciclo_param_if #(
  parameter int unsigned ALUFCT_W = 3,
  parameter int unsigned SEL_W    = 3
);
  logic                ET;
  logic                LT;
  logic [31:0]         Instr31_0;
  logic                LoadIR;
  logic                PCWrite;
  logic                LoadOldPC;
  logic                LoadRegA;
  logic                LoadRegB;
  logic                LoadMDR;
  logic                LoadAluout;
  logic                WriteRegBanco;
  logic                DMemWR;
  logic [SEL_W-1:0]    AluSrcA;
  logic [SEL_W-1:0]    AluSrcB;
  logic [ALUFCT_W-1:0] AluFct;
  logic [SEL_W-1:0]    MemToReg;
  logic [SEL_W-1:0]    InstrType;
  logic [6:0]          State;
  logic                Illegal;

  modport master (
    input  ET, LT, Instr31_0,
    output LoadIR, PCWrite, LoadOldPC, LoadRegA, LoadRegB, LoadMDR,
           LoadAluout, WriteRegBanco, DMemWR, AluSrcA, AluSrcB, AluFct,
           MemToReg, InstrType, State, Illegal
  );

  modport slave (
    output ET, LT, Instr31_0,
    input  LoadIR, PCWrite, LoadOldPC, LoadRegA, LoadRegB, LoadMDR,
           LoadAluout, WriteRegBanco, DMemWR, AluSrcA, AluSrcB, AluFct,
           MemToReg, InstrType, State, Illegal
  );
endinterface

// File: rtl/uc_multiciclo_param.sv
// uc_multiciclo_param
//   Multicycle control unit for the RV64 subset datapath. Sequences fetch,
//   decode, execute, memory and write-back for add/sub/addi/ld/sd/lui and
//   beq/bne/blt/bge, with MEM_LAT wait cycles per memory access.
//   Ports: clock (rising edge), reset (async, active-high -> state RST),
//          bus (uc_multiciclo_param_if.master): flags + IR in, strobes out.
//   Build option: define UC_TRAP_EN to turn undecodable instructions into a
//   trap (Illegal pulse, PC <- trap vector); otherwise they execute as NOP.
module uc_multiciclo_param #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned ALUFCT_W = 3,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  uc_multiciclo_param_if.master  bus
);

  typedef enum logic [6:0] {
    RST      = 7'd0,  FETCH    = 7'd1,  IF_WAIT  = 7'd2,  LOAD_IR  = 7'd3,
    DECODE   = 7'd4,  EX_ADD   = 7'd5,  EX_SUB   = 7'd6,  EX_ADDI  = 7'd7,
    EX_LUI   = 7'd8,  WB_ALU   = 7'd9,  ADDR_LD  = 7'd10, ADDR_SD  = 7'd11,
    DR_WAIT  = 7'd12, LOAD_MDR = 7'd13, WB_MEM   = 7'd14, MEM_WR   = 7'd15,
    DW_WAIT  = 7'd16, BRANCH   = 7'd17, BR_TAKE  = 7'd18, ILLEGAL  = 7'd19
  } state_t;

  // Counter keeps at least one bit so MEM_LAT == 0 still elaborates.
  localparam int unsigned WC_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (MEM_LAT > 0) ? WC_W'(MEM_LAT - 1) : '0;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              wait_done;
  logic              taken;

  logic                load_ir, pc_write, load_old_pc, load_reg_a, load_reg_b;
  logic                load_mdr, load_aluout, write_reg, dmem_wr, illegal;
  logic [SEL_W-1:0]    alu_src_a, alu_src_b, mem_to_reg, instr_type;
  logic [ALUFCT_W-1:0] alu_fct;

  logic unused_instr_bits;

  assign opcode    = bus.Instr31_0[6:0];
  assign funct3    = bus.Instr31_0[14:12];
  assign funct7    = bus.Instr31_0[31:25];
  assign wait_done = (wcnt_q == WC_LAST);
  assign unused_instr_bits = ^{bus.Instr31_0[24:15], bus.Instr31_0[11:7]};

  always_comb begin
    unique case (funct3)
      3'b000:  taken = bus.ET;
      3'b001:  taken = ~bus.ET;
      3'b100:  taken = bus.LT;
      3'b101:  taken = ~bus.LT;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RST;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = '0;
    load_ir     = 1'b0;
    pc_write    = 1'b0;
    load_old_pc = 1'b0;
    load_reg_a  = 1'b0;
    load_reg_b  = 1'b0;
    load_mdr    = 1'b0;
    load_aluout = 1'b0;
    write_reg   = 1'b0;
    dmem_wr     = 1'b0;
    illegal     = 1'b0;
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_fct     = '0;
    mem_to_reg  = '0;
    instr_type  = '0;

    case (state_q)
      RST: state_d = FETCH;

      FETCH: begin
        pc_write    = 1'b1;
        load_old_pc = 1'b1;
        alu_src_b   = SEL_W'(1);
        alu_fct     = ALUFCT_W'(1);
        state_d     = (MEM_LAT == 0) ? LOAD_IR : IF_WAIT;
      end

      // wcnt_d defaults to 0, so any entry into a wait state starts from 0.
      IF_WAIT: if (wait_done) state_d = LOAD_IR; else wcnt_d = wcnt_q + WC_W'(1);

      LOAD_IR: begin
        load_ir = 1'b1;
        state_d = DECODE;
      end

      DECODE: begin
        load_reg_a = 1'b1;
        load_reg_b = 1'b1;
        state_d    = ILLEGAL;
        case (opcode)
          7'b0110011: if (funct3 == 3'b000) begin
            if (funct7 == 7'b0000000)      state_d = EX_ADD;
            else if (funct7 == 7'b0100000) state_d = EX_SUB;
          end
          7'b0010011: if (funct3 == 3'b000) state_d = EX_ADDI;
          7'b0000011: if (funct3 == 3'b011) state_d = ADDR_LD;
          7'b0100011: begin
            instr_type = SEL_W'(1);
            if (funct3 == 3'b011) state_d = ADDR_SD;
          end
          7'b1100011: begin
            instr_type = SEL_W'(2);
            if (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101}) state_d = BRANCH;
          end
          7'b0110111: begin
            instr_type = SEL_W'(4);
            state_d    = EX_LUI;
          end
          default: ;
        endcase
      end

      EX_ADD, EX_SUB: begin
        alu_src_a   = SEL_W'(1);
        alu_fct     = (state_q == EX_SUB) ? ALUFCT_W'(2) : ALUFCT_W'(1);
        load_aluout = 1'b1;
        state_d     = WB_ALU;
      end

      EX_ADDI, EX_LUI: begin
        alu_src_a   = (state_q == EX_LUI) ? SEL_W'(2) : SEL_W'(1);
        alu_src_b   = SEL_W'(2);
        alu_fct     = ALUFCT_W'(1);
        load_aluout = 1'b1;
        state_d     = WB_ALU;
      end

      WB_ALU: begin
        mem_to_reg = SEL_W'(1);
        write_reg  = 1'b1;
        state_d    = FETCH;
      end

      ADDR_LD, ADDR_SD: begin
        alu_src_a   = SEL_W'(1);
        alu_src_b   = SEL_W'(2);
        alu_fct     = ALUFCT_W'(1);
        load_aluout = 1'b1;
        if (state_q == ADDR_SD) state_d = MEM_WR;
        else                    state_d = (MEM_LAT == 0) ? LOAD_MDR : DR_WAIT;
      end

      DR_WAIT: if (wait_done) state_d = LOAD_MDR; else wcnt_d = wcnt_q + WC_W'(1);

      LOAD_MDR: begin
        load_mdr = 1'b1;
        state_d  = WB_MEM;
      end

      WB_MEM: begin
        write_reg = 1'b1;
        state_d   = FETCH;
      end

      MEM_WR: begin
        dmem_wr = 1'b1;
        state_d = (MEM_LAT == 0) ? FETCH : DW_WAIT;
      end

      // Write strobe stays high while the slow memory completes the store.
      DW_WAIT: begin
        dmem_wr = 1'b1;
        if (wait_done) state_d = FETCH; else wcnt_d = wcnt_q + WC_W'(1);
      end

      BRANCH: begin
        alu_src_a = SEL_W'(1);
        alu_fct   = ALUFCT_W'(7);
        state_d   = taken ? BR_TAKE : FETCH;
      end

      // Target is computed from the PC latched during FETCH, not the incremented PC.
      BR_TAKE: begin
        alu_src_a = SEL_W'(3);
        alu_src_b = SEL_W'(2);
        alu_fct   = ALUFCT_W'(1);
        pc_write  = 1'b1;
        state_d   = FETCH;
      end

      ILLEGAL: begin
`ifdef UC_TRAP_EN
        illegal   = 1'b1;
        alu_src_a = SEL_W'(2);
        alu_src_b = SEL_W'(3);
        alu_fct   = ALUFCT_W'(1);
        pc_write  = 1'b1;
`endif
        state_d   = FETCH;
      end

      default: state_d = RST;
    endcase
  end

  assign bus.LoadIR        = load_ir;
  assign bus.PCWrite       = pc_write;
  assign bus.LoadOldPC     = load_old_pc;
  assign bus.LoadRegA      = load_reg_a;
  assign bus.LoadRegB      = load_reg_b;
  assign bus.LoadMDR       = load_mdr;
  assign bus.LoadAluout    = load_aluout;
  assign bus.WriteRegBanco = write_reg;
  assign bus.DMemWR        = dmem_wr;
  assign bus.AluSrcA       = alu_src_a;
  assign bus.AluSrcB       = alu_src_b;
  assign bus.AluFct        = alu_fct;
  assign bus.MemToReg      = mem_to_reg;
  assign bus.InstrType     = instr_type;
  assign bus.State         = state_q;
  assign bus.Illegal       = illegal;

endmodule
